// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// default instruction memory depth and the NOP word used for cleared outputs.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_HALTED
  } fetch_state_e;

  localparam int          IMEM_WORDS_DEFAULT = 128;
  localparam logic [31:0] NOP                = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks the PC through a combinational-read
// instruction memory and hands words to decode over a valid/ready handshake.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] FetchCount
);

  localparam logic [29:0] MEM_WORDS = 30'(IMEM_WORDS);
  localparam logic [29:0] LAST_IDX  = 30'(IMEM_WORDS - 1);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_valid;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_halted;
  logic         r_fault;
  logic [15:0]  r_count;

  logic w_hs;
  logic w_target_bad;
  logic w_last;

  assign w_hs         = r_valid & InstrReady;
  assign w_target_bad = (RedirectTarget[1:0] != 2'b00) || (RedirectTarget[31:2] >= MEM_WORDS);
  assign w_last       = (r_pc[31:2] == LAST_IDX);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= NOP;
      r_instr_pc <= 32'h0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
      r_count    <= 16'h0;
    end else begin
      if (w_hs && (r_count != 16'hFFFF))
        r_count <= r_count + 16'd1;

      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;

        ST_FETCH, ST_HOLD: begin
          if (Halt) begin
            // A held word survives the halt and is drained in HALTED.
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
            if (w_hs)
              r_valid <= 1'b0;
          end else if (Redirect) begin
            r_valid <= 1'b0;
            if (w_target_bad) begin
              r_fault  <= 1'b1;
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else begin
              r_pc    <= RedirectTarget;
              r_state <= ST_FETCH;
            end
          end else if (!r_valid || InstrReady) begin
            r_instr    <= ImemInstruction;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            // The PC stays on the last word so the address never leaves memory.
            if (w_last) begin
              r_fault  <= 1'b1;
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else begin
              r_pc    <= r_pc + 32'd4;
              r_state <= ST_FETCH;
            end
          end else begin
            r_state <= ST_HOLD;
          end
        end

        ST_HALTED: begin
          if (w_hs)
            r_valid <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ImemAddress = r_pc;
  assign InstrValid  = r_valid;
  assign Instruction = r_instr;
  assign InstrPC     = r_instr_pc;
  assign Halted      = r_halted;
  assign Fault       = r_fault;
  assign FetchCount  = r_count;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: word-aligned fetch address loaded at reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 128: number of valid instruction memory words.
REQ-003 SHALL use one clock and an asynchronous active-low reset, exactly so.
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 Rst  in  1  asynchronous active-low reset.
REQ-006 ImemAddress  out  32  fetch address to the instruction memory (combinational read); equals PC.
REQ-007 ImemInstruction  in  32  instruction word returned for ImemAddress in the same cycle.
REQ-008 Redirect  in  1  branch/jump taken; load RedirectTarget into PC.
REQ-009 RedirectTarget  in  32  new fetch address.
REQ-010 Halt  in  1  request to stop fetching.
REQ-011 InstrValid  out  1  Instruction/InstrPC hold a fetched word.
REQ-012 InstrReady  in  1  decode accepts the word when InstrValid is high.
REQ-013 Instruction  out  32  fetched instruction.
REQ-014 InstrPC  out  32  address of Instruction.
REQ-015 Halted  out  1  controller in HALTED.
REQ-016 Fault  out  1  sticky address fault.
REQ-017 FetchCount  out  16  count of accepted handshakes, saturating at 16'hFFFF.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD and HALTED.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to FETCH; no fetch occurs in IDLE.
REQ-020 Fetch condition: state FETCH or HOLD, no Redirect, no Halt, and (InstrValid==0 or InstrReady==1).
REQ-021 On a fetch, the controller SHALL register Instruction<=ImemInstruction, InstrPC<=PC, InstrValid<=1 and PC<=PC+4, with state FETCH.
REQ-022 Latency from PC presentation to InstrValid is one cycle; throughput is one word per cycle while InstrReady==1.
REQ-023 If InstrValid==1 and InstrReady==0, the controller SHALL enter or stay in HOLD with PC and the output registers unchanged.
REQ-024 A handshake (InstrValid && InstrReady) with no new fetch SHALL clear InstrValid.
REQ-025 Redirect in FETCH/HOLD SHALL set PC<=RedirectTarget, clear InstrValid next cycle (flush) and fetch nothing that cycle; a coincident handshake still counts.
REQ-026 A RedirectTarget with bits[1:0]!=0, or with word index (bits[31:2]) >= IMEM_WORDS, SHALL set Fault=1, clear InstrValid and enter HALTED.
REQ-027 If PC+4 would reach word index IMEM_WORDS, the controller SHALL deliver the last word, then set Fault=1 and enter HALTED; it SHALL never drive an out-of-range ImemAddress.
REQ-028 Halt SHALL take priority over Redirect: fetching stops and the state becomes HALTED, but a held word stays valid until accepted.
REQ-029 In HALTED, Redirect and Halt SHALL be ignored, PC SHALL be frozen and Halted=1; only reset exits HALTED.
REQ-030 FetchCount SHALL increment on every handshake, including in HALTED, and saturate at 16'hFFFF.

Reset
REQ-031 Asserting Rst SHALL immediately set PC=RESET_PC, state=IDLE, InstrValid=0, Instruction=0, InstrPC=0, Halted=0, Fault=0 and FetchCount=0.
REQ-032 Reset mid-operation SHALL discard any held word with no handshake credited.
REQ-033 Outputs SHALL be stable from registers; only ImemAddress derives from PC.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, the default IMEM_WORDS and a NOP constant of 32'h0000_0000.
REQ-035 The block SHALL have no sub-modules; the instruction memory is instantiated by the parent and connected via ImemAddress/ImemInstruction.

Verification
REQ-036 Reset release with InstrReady=1 and memory[i]=i*4 -> ImemAddress 0,4,8 on consecutive cycles; InstrValid rises 2 cycles after release; Instruction=0,4,8; FetchCount=3 after 3 handshakes.
REQ-037 InstrReady=0 for 3 cycles with a word held at PC 8 -> Instruction/InstrPC held at 8, PC=12 constant, state HOLD; resumes with 12 on the cycle after InstrReady=1.
REQ-038 Redirect=1, RedirectTarget=0x40 with InstrReady=1 -> InstrValid=0 next cycle, then InstrPC=0x40, then 0x44; the coincident handshake is counted.
REQ-039 RedirectTarget=0x42, then a separate test with 0x200 and IMEM_WORDS=128 -> Fault=1, Halted=1, InstrValid=0; later Redirect is ignored until Rst.
REQ-040 Sequential fetch to PC=0x1FC -> word 0x1FC delivered, then Fault=1 and Halted=1; ImemAddress never exceeds 0x1FC.
REQ-041 Halt and Redirect in the same cycle with a word held and InstrReady=0 -> HALTED; the word stays valid until InstrReady=1, then InstrValid=0 and FetchCount increments once.
